mul_reconstruct: RTL and testbench

Sequential 32×32 shift-add multiplier with remainder add: computes P = D × B + R, reconstructing the dividend from a quotient/remainder pair produced by the 32-bit restoring divider. It sits beside the divider in the arithmetic datapath. It serves two purposes: a standalone multiplier (R = 0), and a round-trip checker for divider results. One bit per cycle, radix-2, single clock domain, with the same start/ok/err style handshake as the divider.

---
 rtl/mul_reconstruct.sv | 112 +++++++++++
 tb/tb_mul_reconstruct.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_reconstruct.sv
// rtl/mul_reconstruct.sv - radix-2 shift-add multiplier computing P = D*B + R
// Rebuilds a dividend from a divider quotient/remainder pair; also usable as a plain multiplier.
module mul_reconstruct (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] D,
  input  logic [31:0] B,
  input  logic [31:0] R,
  output logic [63:0] P,
  output logic        ok,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] radd_q, radd_d;
  logic [4:0]  cycle_q, cycle_d;
  logic [63:0] p_q, p_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [32:0] step_sum;
  logic [63:0] final_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      mcand_q <= 32'd0;
      radd_q  <= 32'd0;
      cycle_q <= 5'd0;
      p_q     <= 64'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      radd_q  <= radd_d;
      cycle_q <= cycle_d;
      p_q     <= p_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // The multiplier bit is consumed from lo while product bits shift in from the top.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    radd_d    = radd_q;
    cycle_d   = cycle_q;
    p_d       = p_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    step_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    final_sum = {hi_q, lo_q} + {32'd0, radd_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d    = D;
          hi_d    = 32'd0;
          mcand_d = B;
          radd_d  = R;
          cycle_d = 5'd31;
          err_d   = (B == 32'd0) || (R >= B);
          ovf_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        hi_d = step_sum[32:1];
        lo_d = {step_sum[0], lo_q[31:1]};
        if (cycle_q == 5'd0) begin
          state_d = ADD;
        end else begin
          cycle_d = cycle_q - 5'd1;
        end
      end
      ADD: begin
        // Max (2^32-1)^2 + 2^32-1 still fits in 64 bits, so no carry out is possible.
        p_d     = final_sum;
        ovf_d   = |final_sum[63:32];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign P   = p_q;
  assign ok  = (state_q == IDLE);
  assign err = err_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mul_reconstruct.sv
// tb/tb_mul_reconstruct.sv - directed and round-trip checks for mul_reconstruct
module tb_mul_reconstruct;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] D;
  logic [31:0] B;
  logic [31:0] R;
  logic [63:0] P;
  logic        ok;
  logic        err;
  logic        ovf;

  int checks;
  int errors;

  mul_reconstruct dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .D     (D),
    .B     (B),
    .R     (R),
    .P     (P),
    .ok    (ok),
    .err   (err),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and count the busy samples (bounded at 100).
  task automatic do_op(input logic [31:0] d, input logic [31:0] b, input logic [31:0] r,
                       output int lat, output logic err_early);
    @(negedge clk);
    D = d; B = b; R = r; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    err_early = err;
    lat = 0;
    while (!ok && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; D = '0; B = '0; R = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (P !== 64'd0 || ok !== 1'b1 || err !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: P=%0h ok=%b err=%b ovf=%b expected P=0 ok=1 err=0 ovf=0", P, ok, err, ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic e0;
    do_op(32'd7, 32'd3, 32'd2, lat, e0);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    checks++;
    if (P !== 64'd23 || err !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL basic_result: P=%0d err=%b ovf=%b expected P=23 err=0 ovf=0", P, err, ovf);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (P !== 64'd23 || ok !== 1'b1) begin
      errors++; $display("FAIL basic_hold: P=%0d ok=%b expected P=23 ok=1", P, ok);
    end
  endtask

  task automatic test_max();
    int lat; logic e0;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, lat, e0);
    checks++;
    if (P !== 64'hFFFFFFFE_FFFFFFFF || ovf !== 1'b1 || err !== 1'b0 || lat !== 33) begin
      errors++; $display("FAIL max_operands: P=%0h ovf=%b err=%b lat=%0d expected P=fffffffeffffffff ovf=1 err=0 lat=33", P, ovf, err, lat);
    end
  endtask

  task automatic test_legality();
    int lat; logic e0;
    do_op(32'd5, 32'd0, 32'd9, lat, e0);
    checks++;
    if (e0 !== 1'b1) begin errors++; $display("FAIL b_zero_err_early: got %b expected 1", e0); end
    checks++;
    if (P !== 64'd9 || err !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL b_zero_result: P=%0d err=%b ovf=%b expected P=9 err=1 ovf=0", P, err, ovf);
    end
    do_op(32'd1, 32'd5, 32'd5, lat, e0);
    checks++;
    if (P !== 64'd10 || err !== 1'b1) begin
      errors++; $display("FAIL r_eq_b: P=%0d err=%b expected P=10 err=1", P, err);
    end
  endtask

  task automatic test_round_trip();
    int lat; logic e0;
    logic [31:0] a, b;
    int bad;
    do_op(32'd14, 32'd7, 32'd2, lat, e0);
    checks++;
    if (P !== 64'd100 || err !== 1'b0) begin
      errors++; $display("FAIL round_trip_100: P=%0d err=%b expected P=100 err=0", P, err);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? $urandom_range(1, 255) : $urandom;
      if (b == 32'd0) b = 32'd1;
      do_op(a / b, b, a % b, lat, e0);
      checks++;
      if (P !== {32'd0, a} || err !== 1'b0 || ovf !== 1'b0 || lat !== 33) begin
        errors++;
        if (bad < 5) $display("FAIL round_trip_rand: A=%0h B=%0h P=%0h err=%b ovf=%b lat=%0d expected P=%0h err=0 ovf=0 lat=33",
                              a, b, P, err, ovf, lat, {32'd0, a});
        bad++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    D = 32'd7; B = 32'd3; R = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!ok && lat < 100) begin
      lat++;
      if (lat == 10) begin
        D = 32'd99; B = 32'd11; R = 32'd4; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (lat !== 33 || P !== 64'd23) begin
      errors++; $display("FAIL busy_ignore: lat=%0d P=%0d expected lat=33 P=23", lat, P);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || P !== 64'd23) begin
      errors++; $display("FAIL busy_no_queue: ok=%b P=%0d expected ok=1 P=23", ok, P);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ones;
    @(negedge clk);
    D = 32'd7; B = 32'd3; R = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    D = 32'd3; B = 32'd4; R = 32'd1;
    lat1 = 0;
    while (!ok && lat1 < 100) begin lat1++; @(negedge clk); end
    checks++;
    if (lat1 !== 33 || P !== 64'd23) begin
      errors++; $display("FAIL b2b_first: lat=%0d P=%0d expected lat=33 P=23", lat1, P);
    end
    ones = 0;
    while (ok && ones < 5) begin ones++; @(negedge clk); end
    checks++;
    if (ones !== 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d expected 1", ones); end
    lat2 = 0;
    while (!ok && lat2 < 100) begin lat2++; @(negedge clk); end
    start = 1'b0;
    checks++;
    if (lat2 !== 33 || P !== 64'd13) begin
      errors++; $display("FAIL b2b_second: lat=%0d P=%0d expected lat=33 P=13", lat2, P);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic e0;
    do_op(32'd7, 32'd3, 32'd2, lat, e0);
    @(negedge clk);
    D = 32'd5; B = 32'd0; R = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (ok !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL abort_busy: ok=%b err=%b expected ok=0 err=1", ok, err);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (P !== 64'd0 || ok !== 1'b1 || err !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL abort_state: P=%0d ok=%b err=%b ovf=%b expected P=0 ok=1 err=0 ovf=0", P, ok, err, ovf);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (P !== 64'd0 || ok !== 1'b1) begin
      errors++; $display("FAIL abort_no_partial: P=%0d ok=%b expected P=0 ok=1", P, ok);
    end
    do_op(32'd3, 32'd4, 32'd1, lat, e0);
    checks++;
    if (lat !== 33 || P !== 64'd13 || err !== 1'b0) begin
      errors++; $display("FAIL abort_restart: lat=%0d P=%0d err=%b expected lat=33 P=13 err=0", lat, P, err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_max();
    test_legality();
    test_round_trip();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
